// File: rtl/cirno_hamming_pkg.sv
// Shared types and size helpers for the Hamming SECDED stream engine.
// R and NB are derived from K/DW so every block sizes itself identically.
package cirno_hamming_pkg;

    typedef enum logic {
        MODE_ENCODE = 1'b0,
        MODE_DECODE = 1'b1
    } mode_e;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_RD   = 3'd2,
        S_CAP  = 3'd3,
        S_CALC = 3'd4,
        S_WR   = 3'd5,
        S_DONE = 3'd6
    } state_e;

    // Smallest r with 2^r >= k + r + 1.
    function automatic int calc_r(input int k);
        int r;
        r = 1;
        while ((1 << r) < (k + r + 1)) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Bytes per stored word, including the overall parity bit when present.
    function automatic int calc_nb(input int k, input int dw, input int secded);
        return (k + calc_r(k) + secded + dw - 1) / dw;
    endfunction

endpackage

// File: rtl/hamming_stream_engine_if.sv
// Control, status and shared byte-memory port of the Hamming stream engine.
// master = engine side, slave = host / memory side.
interface hamming_stream_engine_if #(
    parameter int AW = 8,
    parameter int DW = 8
) ();

    logic          init;
    logic          mode;
    logic [AW-1:0] src_base;
    logic [AW-1:0] dst_base;
    logic [AW-1:0] count;
    logic [AW-1:0] mem_addr;
    logic          mem_wr_en;
    logic [DW-1:0] mem_wr_data;
    logic [DW-1:0] mem_rd_data;
    logic          busy;
    logic          done;
    logic [AW-1:0] n_corr;
    logic [AW-1:0] n_dbl;

    modport master (
        input  init, mode, src_base, dst_base, count, mem_rd_data,
        output mem_addr, mem_wr_en, mem_wr_data, busy, done, n_corr, n_dbl
    );

    modport slave (
        output init, mode, src_base, dst_base, count, mem_rd_data,
        input  mem_addr, mem_wr_en, mem_wr_data, busy, done, n_corr, n_dbl
    );

endinterface

// File: rtl/hamming_secded_core.sv
// Purely combinational Hamming encoder and syndrome decoder/corrector.
// Stored bit j holds codeword position j+1; bit N is the overall parity when SECDED=1.
module hamming_secded_core
    import cirno_hamming_pkg::*;
#(
    parameter int K      = 11,
    parameter int SECDED = 1,
    localparam int R     = calc_r(K),
    localparam int N     = K + R,
    localparam int CW    = N + SECDED
) (
    input  logic [K-1:0]  data_in,
    output logic [CW-1:0] code_out,
    input  logic [CW-1:0] code_in,
    output logic [K-1:0]  data_out,
    output logic          corr,
    output logic          dbl
);

    logic [N:1]   enc_data_s;
    logic [N:1]   enc_pos_s;
    logic [R-1:0] par_s;
    logic [N:1]   dec_pos_s;
    logic [N:1]   fix_pos_s;
    logic [R-1:0] syn_s;
    logic         overall_s;
    logic         single_s;

    // Data bit of position p is index p-1-clog2(p+1): positions minus the powers of two below them.
    for (genvar p = 1; p <= N; p++) begin : g_pos
        if ((p & (p - 1)) == 0) begin : g_par
            assign enc_data_s[p] = 1'b0;
            assign enc_pos_s[p]  = par_s[$clog2(p)];
        end else begin : g_dat
            localparam int DI = p - 1 - $clog2(p + 1);
            assign enc_data_s[p] = data_in[DI];
            assign enc_pos_s[p]  = enc_data_s[p];
            assign data_out[DI]  = fix_pos_s[p];
        end
    end

    // Parity i covers every data position whose index has bit i set.
    always_comb begin
        par_s = '0;
        for (int i = 0; i < R; i++) begin
            for (int p = 1; p <= N; p++) begin
                par_s[i] = par_s[i] ^ (enc_data_s[p] & p[i]);
            end
        end
    end

    assign code_out[N-1:0] = enc_pos_s;

    if (SECDED != 0) begin : g_overall
        assign code_out[N] = ^enc_pos_s;
    end

    assign dec_pos_s = code_in[N-1:0];
    assign overall_s = (SECDED != 0) ? ^code_in : 1'b0;

    // Syndrome: XOR of the indices of all set positions.
    always_comb begin
        syn_s = '0;
        for (int p = 1; p <= N; p++) begin
            syn_s = syn_s ^ (dec_pos_s[p] ? R'(p) : '0);
        end
    end

    assign single_s = (SECDED != 0) ? overall_s : (syn_s != '0);
    assign corr     = single_s;
    assign dbl      = (SECDED != 0) && !overall_s && (syn_s != '0);

    // Flip the addressed position only for a single error; s=0 means the overall bit, which carries no data.
    always_comb begin
        fix_pos_s = dec_pos_s;
        for (int p = 1; p <= N; p++) begin
            fix_pos_s[p] = dec_pos_s[p] ^ (single_s && (syn_s == R'(p)));
        end
    end

endmodule

// File: rtl/hamming_stream_engine.sv
// Streams count multi-byte words through the SECDED core, writing results back to a
// destination region and keeping saturating correction / double-error statistics.
module hamming_stream_engine
    import cirno_hamming_pkg::*;
#(
    parameter int K      = 11,
    parameter int AW     = 8,
    parameter int DW     = 8,
    parameter int SECDED = 1
) (
    input  logic clk,
    input  logic reset,
    hamming_stream_engine_if.master bus
);

    localparam int R   = calc_r(K);
    localparam int N   = K + R;
    localparam int CW  = N + SECDED;
    localparam int NB  = calc_nb(K, DW, SECDED);
    localparam int WW  = NB * DW;
    localparam int BIW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [BIW-1:0] LAST_BYTE = BIW'(NB - 1);
    localparam logic [AW-1:0]  CNT_MAX   = '1;

    if (K + 2 > WW) begin : g_cfg_check
        $error("hamming_stream_engine: K+2 exceeds NB*DW, no room for status flags");
    end

    state_e         state_r;
    state_e         state_d;
    logic [BIW-1:0] byte_r;
    logic [BIW-1:0] byte_d;
    mode_e          mode_r;
    logic [AW-1:0]  words_left_r;
    logic [AW-1:0]  rd_ptr_r;
    logic [AW-1:0]  wr_ptr_r;
    logic [AW-1:0]  n_corr_r;
    logic [AW-1:0]  n_dbl_r;
    logic [WW-1:0]  rd_buf_r;
    logic [WW-1:0]  res_r;
    logic [AW-1:0]  mem_addr_r;
    logic           mem_wr_en_r;
    logic [DW-1:0]  mem_wr_data_r;
    logic           busy_r;
    logic           done_r;

    logic           start_s;
    logic           last_byte_s;
    logic           cap_s;
    logic [CW-1:0]  code_s;
    logic [K-1:0]   data_s;
    logic           corr_s;
    logic           dbl_s;
    logic [WW-1:0]  dec_word_s;
    logic [WW-1:0]  res_s;
    logic [WW-1:0]  wr_src_s;
    logic [AW-1:0]  addr_d;
    logic           wr_en_d;
    logic [DW-1:0]  wr_data_d;

    hamming_secded_core #(
        .K      (K),
        .SECDED (SECDED)
    ) u_core (
        .data_in  (rd_buf_r[K-1:0]),
        .code_out (code_s),
        .code_in  (rd_buf_r[CW-1:0]),
        .data_out (data_s),
        .corr     (corr_s),
        .dbl      (dbl_s)
    );

    assign start_s     = bus.init && ((state_r == S_IDLE) || (state_r == S_DONE));
    assign last_byte_s = (byte_r == LAST_BYTE);
    // Read data lags the address by one cycle, so byte b lands during RD(b+1) or CAP.
    assign cap_s       = ((state_r == S_RD) && (byte_r != '0)) || (state_r == S_CAP);
    assign dec_word_s  = WW'(data_s) | (WW'(corr_s) << (WW - 2)) | (WW'(dbl_s) << (WW - 1));
    assign res_s       = (mode_r == MODE_DECODE) ? dec_word_s : WW'(code_s);
    assign wr_src_s    = (state_r == S_CALC) ? res_s : res_r;

    // State and byte-index register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_IDLE;
            byte_r  <= '0;
        end else begin
            state_r <= state_d;
            byte_r  <= byte_d;
        end
    end

    // Next-state and byte-index logic.
    always_comb begin
        state_d = state_r;
        byte_d  = '0;
        case (state_r)
            S_IDLE, S_DONE: begin
                if (start_s) begin
                    state_d = S_LOAD;
                end else begin
                    state_d = state_r;
                end
            end
            S_LOAD: begin
                if (words_left_r == '0) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_RD;
                end
            end
            S_RD: begin
                if (last_byte_s) begin
                    state_d = S_CAP;
                end else begin
                    state_d = S_RD;
                    byte_d  = byte_r + BIW'(1);
                end
            end
            S_CAP:  state_d = S_CALC;
            S_CALC: state_d = S_WR;
            S_WR: begin
                if (!last_byte_s) begin
                    state_d = S_WR;
                    byte_d  = byte_r + BIW'(1);
                end else if (words_left_r == AW'(1)) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_RD;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Next values of the registered memory-port outputs, keyed on the state being entered.
    always_comb begin
        addr_d    = mem_addr_r;
        wr_en_d   = 1'b0;
        wr_data_d = mem_wr_data_r;
        case (state_d)
            S_RD: addr_d = rd_ptr_r;
            S_WR: begin
                addr_d    = wr_ptr_r;
                wr_en_d   = 1'b1;
                wr_data_d = wr_src_s[DW-1:0];
            end
            default: addr_d = mem_addr_r;
        endcase
    end

    // Run parameters, byte pointers, word buffers and statistics.
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_r       <= MODE_ENCODE;
            words_left_r <= '0;
            rd_ptr_r     <= '0;
            wr_ptr_r     <= '0;
            n_corr_r     <= '0;
            n_dbl_r      <= '0;
            rd_buf_r     <= '0;
            res_r        <= '0;
        end else begin
            if (start_s) begin
                mode_r       <= mode_e'(bus.mode);
                rd_ptr_r     <= bus.src_base;
                wr_ptr_r     <= bus.dst_base;
                words_left_r <= bus.count;
                n_corr_r     <= '0;
                n_dbl_r      <= '0;
            end else begin
                if (state_d == S_RD) begin
                    rd_ptr_r <= rd_ptr_r + AW'(1);
                end
                if (state_d == S_WR) begin
                    wr_ptr_r <= wr_ptr_r + AW'(1);
                end
                if ((state_r == S_WR) && last_byte_s) begin
                    words_left_r <= words_left_r - AW'(1);
                end
                if ((state_r == S_CALC) && (mode_r == MODE_DECODE)) begin
                    if (corr_s && (n_corr_r != CNT_MAX)) begin
                        n_corr_r <= n_corr_r + AW'(1);
                    end
                    if (dbl_s && (n_dbl_r != CNT_MAX)) begin
                        n_dbl_r <= n_dbl_r + AW'(1);
                    end
                end
            end
            if (cap_s) begin
                rd_buf_r <= (rd_buf_r >> DW) | (WW'(bus.mem_rd_data) << (WW - DW));
            end
            if (state_d == S_WR) begin
                res_r <= wr_src_s >> DW;
            end
        end
    end

    // Registered port outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_addr_r    <= '0;
            mem_wr_en_r   <= 1'b0;
            mem_wr_data_r <= '0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            mem_addr_r    <= addr_d;
            mem_wr_en_r   <= wr_en_d;
            mem_wr_data_r <= wr_data_d;
            busy_r        <= (state_d != S_IDLE) && (state_d != S_DONE);
            done_r        <= (state_d == S_DONE);
        end
    end

    assign bus.mem_addr    = mem_addr_r;
    assign bus.mem_wr_en   = mem_wr_en_r;
    assign bus.mem_wr_data = mem_wr_data_r;
    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.n_corr      = n_corr_r;
    assign bus.n_dbl       = n_dbl_r;

endmodule

// File: tb/tb_hamming_stream_engine.sv
// Directed self-checking bench for hamming_stream_engine at default parameters (K=11, 2-byte words).
module tb_hamming_stream_engine;

    logic clk;
    logic reset;
    logic       tb_we;
    logic [7:0] tb_wa;
    logic [7:0] tb_wd;
    logic [7:0] mem [0:255];
    int wr_count = 0;
    int n_checks = 0;
    int n_errors = 0;

    hamming_stream_engine_if #(.AW(8), .DW(8)) bus ();

    hamming_stream_engine #(
        .K      (11),
        .AW     (8),
        .DW     (8),
        .SECDED (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte memory: one-cycle read latency, bench preload port takes priority.
    always @(posedge clk) begin
        if (tb_we) begin
            mem[tb_wa] <= tb_wd;
        end else if (bus.mem_wr_en) begin
            mem[bus.mem_addr] <= bus.mem_wr_data;
            wr_count <= wr_count + 1;
        end
        bus.mem_rd_data <= mem[bus.mem_addr];
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic poke16(input logic [7:0] a, input logic [15:0] w);
        tb_we = 1'b1;
        tb_wa = a;
        tb_wd = w[7:0];
        @(posedge clk); #1;
        tb_wa = a + 8'd1;
        tb_wd = w[15:8];
        @(posedge clk); #1;
        tb_we = 1'b0;
    endtask

    function automatic logic [15:0] peek16(input logic [7:0] a);
        logic [7:0] a1;
        a1 = a + 8'd1;
        return {mem[a1], mem[a]};
    endfunction

    // Reference: parity bits are chosen so the data-only syndrome cancels.
    function automatic logic [15:0] ref_encode(input logic [10:0] d);
        logic [15:0] cw;
        logic [3:0] s;
        int k;
        cw = 16'h0000;
        s = 4'h0;
        k = 0;
        for (int p = 1; p <= 15; p++) begin
            if (p != 1 && p != 2 && p != 4 && p != 8) begin
                cw[p-1] = d[k];
                if (d[k]) s = s ^ 4'(p);
                k++;
            end
        end
        cw[0] = s[0];
        cw[1] = s[1];
        cw[3] = s[2];
        cw[7] = s[3];
        cw[15] = ^cw[14:0];
        return cw;
    endfunction

    // Pulses init (t0 is the sampling edge) and counts edges until done, bounded.
    task automatic run_engine(input logic m, input logic [7:0] src, input logic [7:0] dst,
                              input logic [7:0] cnt, output int cyc);
        bus.mode = m;
        bus.src_base = src;
        bus.dst_base = dst;
        bus.count = cnt;
        bus.init = 1'b1;
        @(posedge clk); #1;
        bus.init = 1'b0;
        check_val("busy_after_init", bus.busy, 1);
        cyc = 0;
        while (!bus.done && cyc < 2000) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    initial begin
        int cyc;
        int snap;
        logic [10:0] d_tab [15];
        logic [15:0] cw;
        logic [7:0] a;
        int fb;

        reset = 1'b1;
        tb_we = 1'b0;
        tb_wa = 8'h00;
        tb_wd = 8'h00;
        bus.init = 1'b0;
        bus.mode = 1'b0;
        bus.src_base = 8'h00;
        bus.dst_base = 8'h00;
        bus.count = 8'h00;
        repeat (3) @(posedge clk); #1;
        check_val("rst_busy", bus.busy, 0);
        check_val("rst_done", bus.done, 0);
        check_val("rst_wr_en", bus.mem_wr_en, 0);
        check_val("rst_addr", bus.mem_addr, 0);
        check_val("rst_wr_data", bus.mem_wr_data, 0);
        check_val("rst_n_corr", bus.n_corr, 0);
        check_val("rst_n_dbl", bus.n_dbl, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Encode d=0x001 -> 0x8007
        poke16(8'h10, 16'h0001);
        run_engine(1'b0, 8'h10, 8'h20, 8'd1, cyc);
        check_val("enc1_lat", cyc, 7);
        check_val("enc1_lo", mem[8'h20], 8'h07);
        check_val("enc1_hi", mem[8'h21], 8'h80);
        check_val("enc1_done", bus.done, 1);

        // Single error at position 5
        poke16(8'h10, 16'h8017);
        run_engine(1'b1, 8'h10, 8'h20, 8'd1, cyc);
        check_val("decA_word", peek16(8'h20), 16'h4001);
        check_val("decA_n_corr", bus.n_corr, 1);
        check_val("decA_n_dbl", bus.n_dbl, 0);

        // Double error at positions 3 and 5
        poke16(8'h10, 16'h8013);
        run_engine(1'b1, 8'h10, 8'h20, 8'd1, cyc);
        check_val("decB_word", peek16(8'h20), 16'h8002);
        check_val("decB_n_corr", bus.n_corr, 0);
        check_val("decB_n_dbl", bus.n_dbl, 1);

        // Overall bit flipped, then a clean word
        poke16(8'h10, 16'h0007);
        poke16(8'h12, 16'h8007);
        run_engine(1'b1, 8'h10, 8'h20, 8'd2, cyc);
        check_val("decC_lat", cyc, 13);
        check_val("decC_w0", peek16(8'h20), 16'h4001);
        check_val("decC_w1", peek16(8'h22), 16'h0001);
        check_val("decC_n_corr", bus.n_corr, 1);
        check_val("decC_n_dbl", bus.n_dbl, 0);

        // 15 random words: encode 0 -> 30, then decode flipped copies 64 -> 94
        for (int i = 0; i < 15; i++) begin
            d_tab[i] = 11'($urandom_range(2047, 0));
            poke16(8'(2 * i), {5'b00000, d_tab[i]});
        end
        run_engine(1'b0, 8'd0, 8'd30, 8'd15, cyc);
        check_val("enc15_lat", cyc, 91);
        for (int i = 0; i < 15; i++) begin
            a = 8'(30 + 2 * i);
            check_val($sformatf("enc15_w%0d", i), peek16(a), ref_encode(d_tab[i]));
        end
        for (int i = 0; i < 15; i++) begin
            fb = $urandom_range(15, 0);
            cw = ref_encode(d_tab[i]) ^ (16'h0001 << fb);
            poke16(8'(64 + 2 * i), cw);
        end
        run_engine(1'b1, 8'd64, 8'd94, 8'd15, cyc);
        check_val("dec15_lat", cyc, 91);
        for (int i = 0; i < 15; i++) begin
            a = 8'(94 + 2 * i);
            check_val($sformatf("dec15_w%0d", i), peek16(a), {5'b01000, d_tab[i]});
        end
        check_val("dec15_n_corr", bus.n_corr, 15);
        check_val("dec15_n_dbl", bus.n_dbl, 0);

        // count = 0
        snap = wr_count;
        run_engine(1'b0, 8'd0, 8'd200, 8'd0, cyc);
        check_val("cnt0_lat", cyc, 1);
        repeat (3) @(posedge clk); #1;
        check_val("cnt0_writes", wr_count, snap);
        check_val("cnt0_done_held", bus.done, 1);

        // Reset during the first write of word 3
        bus.mode = 1'b1;
        bus.src_base = 8'd64;
        bus.dst_base = 8'd160;
        bus.count = 8'd8;
        bus.init = 1'b1;
        @(posedge clk); #1;
        bus.init = 1'b0;
        cyc = 0;
        while (!(bus.mem_wr_en && bus.mem_addr == 8'd166) && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        check_val("mid_reach_wr3", cyc, 23);
        check_val("mid_n_corr", bus.n_corr, 4);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        snap = wr_count;
        check_val("mid_busy", bus.busy, 0);
        check_val("mid_done", bus.done, 0);
        check_val("mid_wr_en", bus.mem_wr_en, 0);
        check_val("mid_addr", bus.mem_addr, 0);
        check_val("mid_n_corr0", bus.n_corr, 0);
        check_val("mid_n_dbl0", bus.n_dbl, 0);
        repeat (20) @(posedge clk); #1;
        check_val("mid_no_writes", wr_count, snap);

        // Re-run across the address wrap: words at 254..255 and 0..1
        poke16(8'd254, 16'h8017);
        poke16(8'd0, 16'h8013);
        run_engine(1'b1, 8'd254, 8'd200, 8'd2, cyc);
        check_val("wrap_lat", cyc, 13);
        check_val("wrap_w0", peek16(8'd200), 16'h4001);
        check_val("wrap_w1", peek16(8'd202), 16'h8002);
        check_val("wrap_n_corr", bus.n_corr, 1);
        check_val("wrap_n_dbl", bus.n_dbl, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hamming_stream_engine.md
# hamming_stream_engine

Parametrised Hamming SECDED codec engine for the cirno processor: on an `init` pulse it streams `count` little-endian multi-byte words from data memory, encodes or decodes/corrects each, and writes the results back to a destination region. It sits beside `DATA_MEM` on a shared byte port. It is the hardware successor of the software encode (program 1) and correct (program 2) routines. It generalises data width and adds double-error detection and per-run error statistics.

## Interface
Parameters:
- `K`, 11, data bits per message.
- `AW`, 8, memory address width.
- `DW`, 8, memory data width (bytes).
- `SECDED`, 1, 1 = extra overall-parity bit plus double-error detect; 0 = plain Hamming SEC.
- Derived, not overridable: `R` = smallest r with 2^r ≥ K+r+1 (4 at default); `N` = K+R; `NB` = ceil((N+SECDED)/DW) (2 at default). Elaboration error unless K+2 ≤ NB·DW.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high.
- `init`  in  1  start pulse; sampled only in IDLE or DONE.
- `mode`  in  1  0 = encode, 1 = decode; latched with `init`.
- `src_base`  in  AW  first source byte address; latched with `init`.
- `dst_base`  in  AW  first destination byte address; latched with `init`.
- `count`  in  AW  number of words; latched with `init`.
- `mem_addr`  out  AW  byte address.
- `mem_wr_en`  out  1  write strobe.
- `mem_wr_data`  out  DW  write byte.
- `mem_rd_data`  in  DW  read byte, valid the cycle after `mem_addr` is presented.
- `busy`  out  1  high from LOAD until DONE.
- `done`  out  1  level; high in DONE until the next accepted `init` or `reset`.
- `n_corr`  out  AW  words with a corrected single error (decode only).
- `n_dbl`  out  AW  words flagged as double error (decode only).

## Operation
- Word i occupies bytes base+NB·i … base+NB·i+NB−1, least-significant byte first. Address arithmetic is modulo 2^AW and wraps silently.
- Encode: input bits [K−1:0] = d[K:1]. Codeword positions 1..N hold parity at powers of two and data in ascending order elsewhere. Stored bit j = position j+1. If SECDED=1, bit N = XOR of positions 1..N. All higher bits are 0.
- Decode:
  - syndrome s = XOR of the indices of all set positions; o = XOR of all N+SECDED stored bits.
  - SECDED=1:
    - s=0, o=0: clean.
    - o=1: single error. Flip position s if s≠0; s=0 means the overall bit itself. Increment `n_corr`.
    - s≠0, o=0: double error. Data is passed through unmodified. Increment `n_dbl`.
  - SECDED=0: s≠0 → flip and increment `n_corr`.
  - Output word: [K−1:0] data; bit NB·DW−2 = corrected flag; bit NB·DW−1 = double-error flag; other bits 0.
- Counters saturate at 2^AW−1. They clear on an accepted `init` and on `reset`.
- FSM: IDLE → (init) LOAD → RD(0..NB−1) → CAP → CALC → WR(0..NB−1) → next word, or DONE when all words are processed. `count`=0 goes LOAD → DONE. DONE → (init) LOAD.
- `init` while busy is ignored.
- A read and a write are never issued in the same cycle. `mem_wr_en` is high only in WR states.

## Timing
- Reset values: `busy`=0, `done`=0, `mem_wr_en`=0, `mem_addr`=0, `mem_wr_data`=0, `n_corr`=0, `n_dbl`=0; state IDLE.
- `init` is sampled at edge t0. The engine is in LOAD during cycle t0..t0+1.
- Each word takes exactly 2·NB+2 cycles (6 at default). The result is registered in CALC.
- `done` rises at edge t0+1+(2·NB+2)·count. With count=0 this is t0+1.
- `reset` asserted mid-run: at the next edge the engine returns to IDLE and all outputs take their reset values. No partial write is issued after that edge.

## Structure
- Package `cirno_hamming_pkg`: `mode_e`, `state_e`, and functions computing R and NB from K/DW.
- Sub-module `hamming_secded_core`: purely combinational encode/syndrome/correct datapath parameterised by K and SECDED. The FSM, address counters and statistics stay in `hamming_stream_engine`.

## Test plan
- Encode, default params: d=0x001 → bytes 0x07, 0x80 at `dst_base`; `done` at t0+7 for count=1.
- Decode 0x8017 (position 5 flipped) → 0x4001; `n_corr`=1, `n_dbl`=0.
- Decode 0x8013 (positions 3 and 5 flipped) → 0x8002; `n_dbl`=1.
- Decode 0x0007 (only the overall bit flipped) → 0x4001. Decode 0x8007 → 0x0001 with no counter change.
- 15 random words encoded from src 0 to dst 30, then decoded from 64 to 94 with random single flips: every output matches a reference model; `done` at t0+91. A count=0 run gives `done` at t0+1 with no writes.
- Pulse `reset` during the WR states of word 3: the engine is in IDLE next cycle, no further `mem_wr_en`, and counters are 0. A following `init` re-runs correctly. With `src_base`=254 the run wraps to address 0.
